// File: rtl/memctrl_banked.sv
// memctrl_banked: banked SRAM controller with host command staging.
// Host commands ({WEB,OEB,ADDR,IDATA}) are staged on CLK whenever CSB is low.
// A synchronised rising edge of the asynchronous CE strobe launches the staged
// command into one of NUM_BANKS SRAM macros. The top log2(NUM_BANKS) address
// bits select the bank.
// Optional macro MEMCTRL_BISR_EN adds a small spare-word table that redirects
// accesses to logged faulty addresses into spare registers.
//
// Handshake: there is no ready/valid pair on the host side. A CE rise is
// accepted only when the FSM is idle and a command is staged. A CE rise that
// arrives while BUSY is dropped and sets the sticky OVR flag. A CE rise with
// nothing staged is ignored.
module memctrl_banked #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int NUM_BANKS  = 4,
    parameter int MEM_RD_LAT = 1,
    parameter int SPARE_N    = 4
) (
    input  logic                                    CLK,
    input  logic                                    RSTN,
    input  logic                                    CE,
    input  logic                                    CSB,
    input  logic                                    WEB,
    input  logic                                    OEB,
    input  logic [ADDR_W-1:0]                       ADDR,
    input  logic [DATA_W-1:0]                       IDATA,
    output logic [DATA_W-1:0]                       ODATA,
    output logic                                    BUSY,
    output logic                                    OVR,
    output logic [NUM_BANKS-1:0]                    MEM_CEN,
    output logic                                    MEM_WEN,
    output logic [ADDR_W-$clog2(NUM_BANKS)-1:0]     MEM_A,
    output logic [DATA_W-1:0]                       MEM_D,
    input  logic [NUM_BANKS*DATA_W-1:0]             MEM_Q,
    input  logic                                    FAIL_VLD,
    input  logic [ADDR_W-1:0]                       FAIL_ADDR,
    output logic [1:0]                              DBG_STATE
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int LOC_W  = ADDR_W - BANK_W;
    localparam int SEL_W  = (BANK_W > 0) ? BANK_W : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [2:0]          ce_sync_q, ce_sync_d;
    logic                stg_v_q, stg_v_d;
    logic                stg_web_q, stg_web_d;
    logic                stg_oeb_q, stg_oeb_d;
    logic [ADDR_W-1:0]   stg_addr_q, stg_addr_d;
    logic [DATA_W-1:0]   stg_data_q, stg_data_d;
    logic                cmd_web_q, cmd_web_d;
    logic                cmd_oeb_q, cmd_oeb_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;
    logic [DATA_W-1:0]   odata_q, odata_d;
    logic                ovr_q, ovr_d;

    logic                ce_rise;
    logic [SEL_W-1:0]    bank_sel;
    logic [DATA_W-1:0]   bank_rdata;
    logic                spare_hit;
    logic [DATA_W-1:0]   spare_rdata;

    // The bank comes from the launched command register. It therefore stays
    // stable through WAIT and CAPTURE, even if a new command is staged.
    generate
        if (BANK_W > 0) begin : g_bank
            assign bank_sel = cmd_addr_q[ADDR_W-1 -: SEL_W];
        end else begin : g_nobank
            assign bank_sel = '0;
        end
    endgenerate

    assign ce_rise    = ce_sync_q[1] & ~ce_sync_q[2];
    assign bank_rdata = MEM_Q[bank_sel*DATA_W +: DATA_W];

`ifdef MEMCTRL_BISR_EN
    logic              sp_v_q    [SPARE_N];
    logic              sp_v_d    [SPARE_N];
    logic [ADDR_W-1:0] sp_addr_q [SPARE_N];
    logic [ADDR_W-1:0] sp_addr_d [SPARE_N];
    logic [DATA_W-1:0] sp_data_q [SPARE_N];
    logic [DATA_W-1:0] sp_data_d [SPARE_N];
    logic              fail_present;
    logic              slot_taken;

    // Spare table: look up the hit, append new faulty addresses, and write spare data.
    always_comb begin
        spare_hit    = 1'b0;
        spare_rdata  = '0;
        fail_present = 1'b0;
        slot_taken   = 1'b0;
        for (int i = 0; i < SPARE_N; i++) begin
            sp_v_d[i]    = sp_v_q[i];
            sp_addr_d[i] = sp_addr_q[i];
            sp_data_d[i] = sp_data_q[i];
            if (sp_v_q[i] && sp_addr_q[i] == cmd_addr_q) begin
                spare_hit   = 1'b1;
                spare_rdata = sp_data_q[i];
            end
            if (sp_v_q[i] && sp_addr_q[i] == FAIL_ADDR) begin
                fail_present = 1'b1;
            end
        end
        for (int i = 0; i < SPARE_N; i++) begin
            // Entries fill in order, so the first invalid slot is the append point.
            if (FAIL_VLD && !fail_present && !slot_taken && !sp_v_q[i]) begin
                sp_v_d[i]    = 1'b1;
                sp_addr_d[i] = FAIL_ADDR;
                slot_taken   = 1'b1;
            end
            if (state_q == S_ACCESS && !cmd_web_q && sp_v_q[i] && sp_addr_q[i] == cmd_addr_q) begin
                sp_data_d[i] = cmd_data_q;
            end
        end
    end

    // Spare table registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < SPARE_N; i++) begin
                sp_v_q[i]    <= 1'b0;
                sp_addr_q[i] <= '0;
                sp_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SPARE_N; i++) begin
                sp_v_q[i]    <= sp_v_d[i];
                sp_addr_q[i] <= sp_addr_d[i];
                sp_data_q[i] <= sp_data_d[i];
            end
        end
    end
`else
    logic unused_bisr;
    assign unused_bisr = ^{FAIL_VLD, FAIL_ADDR};
    assign spare_hit   = 1'b0;
    assign spare_rdata = '0;
`endif

    // Next state: CE synchroniser, access FSM, read capture, overrun flag, staging.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ce_sync_d  = {ce_sync_q[1:0], CE};
        stg_v_d    = stg_v_q;
        stg_web_d  = stg_web_q;
        stg_oeb_d  = stg_oeb_q;
        stg_addr_d = stg_addr_q;
        stg_data_d = stg_data_q;
        cmd_web_d  = cmd_web_q;
        cmd_oeb_d  = cmd_oeb_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        odata_d    = odata_q;
        ovr_d      = ovr_q;

        case (state_q)
            S_IDLE: begin
                if (ce_rise && stg_v_q) begin
                    cmd_web_d  = stg_web_q;
                    cmd_oeb_d  = stg_oeb_q;
                    cmd_addr_d = stg_addr_q;
                    cmd_data_d = stg_data_q;
                    stg_v_d    = 1'b0;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!cmd_web_q) begin
                    state_d = S_IDLE;
                end else if (MEM_RD_LAT > 1) begin
                    cnt_d   = 2'(MEM_RD_LAT - 2);
                    state_d = S_WAIT;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_CAPTURE: begin
                if (!cmd_oeb_q) begin
                    odata_d = spare_hit ? spare_rdata : bank_rdata;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (ce_rise && state_q != S_IDLE) begin
            ovr_d = 1'b1;
        end

        // Staging comes after the launch clear. A command staged in the
        // launch cycle therefore keeps STG_V set.
        if (!CSB) begin
            stg_v_d    = 1'b1;
            stg_web_d  = WEB;
            stg_oeb_d  = OEB;
            stg_addr_d = ADDR;
            stg_data_d = IDATA;
        end
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ce_sync_q  <= '0;
            stg_v_q    <= 1'b0;
            stg_web_q  <= 1'b1;
            stg_oeb_q  <= 1'b1;
            stg_addr_q <= '0;
            stg_data_q <= '0;
            cmd_web_q  <= 1'b1;
            cmd_oeb_q  <= 1'b1;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            odata_q    <= '0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ce_sync_q  <= ce_sync_d;
            stg_v_q    <= stg_v_d;
            stg_web_q  <= stg_web_d;
            stg_oeb_q  <= stg_oeb_d;
            stg_addr_q <= stg_addr_d;
            stg_data_q <= stg_data_d;
            cmd_web_q  <= cmd_web_d;
            cmd_oeb_q  <= cmd_oeb_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            odata_q    <= odata_d;
            ovr_q      <= ovr_d;
        end
    end

    // SRAM strobes are active only in ACCESS, and only on a spare-table miss.
    always_comb begin
        MEM_CEN = '1;
        MEM_WEN = 1'b1;
        if (state_q == S_ACCESS && !spare_hit) begin
            MEM_CEN[bank_sel] = 1'b0;
            MEM_WEN           = cmd_web_q;
        end
    end

    assign MEM_A     = cmd_addr_q[LOC_W-1:0];
    assign MEM_D     = cmd_data_q;
    assign ODATA     = odata_q;
    assign BUSY      = (state_q != S_IDLE);
    assign OVR       = ovr_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_memctrl_banked.sv
// Testbench for memctrl_banked at default parameters.
// It uses a behavioural 4-bank SRAM with 1-cycle read latency.
// Define MEMCTRL_BISR_EN to also exercise the spare-word redirect.
module tb_memctrl_banked;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        csb;
  logic        web;
  logic        oeb;
  logic [15:0] addr;
  logic [7:0]  idata;
  logic [7:0]  odata;
  logic        busy;
  logic        ovr;
  logic [3:0]  mem_cen;
  logic        mem_wen;
  logic [13:0] mem_a;
  logic [7:0]  mem_d;
  logic [31:0] mem_q;
  logic        fail_vld;
  logic [15:0] fail_addr;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;

  logic [7:0] sram [4][16384];
  logic [7:0] q_r [4];
  logic [7:0] mdl [logic [15:0]];
  logic [7:0] exp_q [$];
  logic [7:0] last_odata;

  memctrl_banked dut (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .CSB(csb), .WEB(web), .OEB(oeb),
    .ADDR(addr), .IDATA(idata), .ODATA(odata), .BUSY(busy), .OVR(ovr),
    .MEM_CEN(mem_cen), .MEM_WEN(mem_wen), .MEM_A(mem_a), .MEM_D(mem_d),
    .MEM_Q(mem_q), .FAIL_VLD(fail_vld), .FAIL_ADDR(fail_addr),
    .DBG_STATE(dbg_state)
  );

  // clock / sram model / access counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!mem_cen[b]) begin
        if (!mem_wen) sram[b][mem_a] <= mem_d;
        else          q_r[b] <= sram[b][mem_a];
      end
    end
    if (mem_cen !== 4'hF) acc_cnt <= acc_cnt + 1;
  end
  assign mem_q = {q_r[3], q_r[2], q_r[1], q_r[0]};

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Stage a command, pulse CE, and check the launch timing.
  // Read data is compared 5 clocks after the CE rise.
  task automatic access(input logic w, input logic o, input logic [15:0] a,
                        input logic [7:0] d, input logic to_sram);
    logic [3:0] ecen;
    logic [7:0] e;
    int a0;
    ecen = to_sram ? ~(4'b0001 << a[15:14]) : 4'hF;
    if (!w) mdl[a] = d;
    else if (!o) exp_q.push_back(mdl.exists(a) ? mdl[a] : 8'h00);
    else exp_q.push_back(last_odata);
    @(negedge clk);
    csb = 1'b0; web = w; oeb = o; addr = a; idata = d;
    @(negedge clk);
    csb = 1'b1; ce = 1'b1; a0 = acc_cnt;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3) begin
        ce = 1'b0;
        n_vec++;
        if (mem_cen !== ecen) begin
          n_err++; $display("FAIL cen_launch a=%h got %b want %b", a, mem_cen, ecen);
        end
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++; $display("FAIL busy_launch got %b want 1", busy);
        end
        if (to_sram) begin
          n_vec++;
          if (mem_a !== a[13:0] || mem_wen !== w) begin
            n_err++; $display("FAIL mem_a_wen got %h/%b want %h/%b", mem_a, mem_wen, a[13:0], w);
          end
          if (!w) begin
            n_vec++;
            if (mem_d !== d) begin
              n_err++; $display("FAIL mem_d got %h want %h", mem_d, d);
            end
          end
        end
      end else begin
        n_vec++;
        if (mem_cen !== 4'hF) begin
          n_err++; $display("FAIL cen_idle k=%0d got %b want 1111", k, mem_cen);
        end
      end
      if (k == 2) begin
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++; $display("FAIL busy_early got %b want 0", busy);
        end
      end
      if (k == 5 && w) begin
        e = exp_q.pop_front();
        last_odata = e;
        n_vec++;
        if (odata !== e) begin
          n_err++; $display("FAIL odata_read a=%h oeb=%b got %h want %h", a, o, odata, e);
        end
      end
    end
    n_vec++;
    if (busy !== 1'b0 || (acc_cnt - a0) != (to_sram ? 1 : 0)) begin
      n_err++; $display("FAIL access_done busy=%b accesses=%0d want 0/%0d", busy, acc_cnt - a0, to_sram ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b0; csb = 1'b1; web = 1'b1; oeb = 1'b1;
    addr = '0; idata = '0; fail_vld = 1'b0; fail_addr = '0;
    last_odata = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++;
    if (odata !== 8'h00 || mem_cen !== 4'hF || busy !== 1'b0 || ovr !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs odata=%h cen=%b busy=%b ovr=%b want 00/1111/0/0", odata, mem_cen, busy, ovr);
    end
    n_vec++;
    if (mem_wen !== 1'b1 || mem_a !== 14'h0 || mem_d !== 8'h00 || dbg_state !== 2'd0) begin
      n_err++; $display("FAIL reset_mem wen=%b a=%h d=%h st=%0d want 1/0/0/0", mem_wen, mem_a, mem_d, dbg_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    access(1'b0, 1'b0, 16'h4012, 8'hA5, 1'b1);
    access(1'b1, 1'b0, 16'h4012, 8'h00, 1'b1);
  endtask

  task automatic test_oeb_hold();
    access(1'b0, 1'b0, 16'h8033, 8'h3C, 1'b1);
    access(1'b1, 1'b1, 16'h8033, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    logic [15:0] al [8];
    logic [1:0] bk;
    logic [7:0] dv;
    logic ob;
    for (int i = 0; i < 8; i++) begin
      bk = 2'($urandom_range(0, 3));
      dv = 8'($urandom_range(0, 255));
      al[i] = {bk, 14'(100 + i * 37)};
      access(1'b0, 1'b0, al[i], dv, 1'b1);
    end
    for (int i = 7; i >= 0; i--) begin
      ob = 1'($urandom_range(0, 1));
      access(1'b1, ob, al[i], 8'h00, 1'b1);
    end
  endtask

  task automatic test_no_stage();
    int a0;
    a0 = acc_cnt;
    @(negedge clk); ce = 1'b1;
    @(negedge clk); ce = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if (acc_cnt != a0 || busy !== 1'b0 || ovr !== 1'b0) begin
      n_err++; $display("FAIL no_stage accesses=%0d busy=%b ovr=%b want 0/0/0", acc_cnt - a0, busy, ovr);
    end
  endtask

  task automatic test_overrun();
    int a0;
    logic [7:0] e;
    exp_q.push_back(mdl[16'h4012]);
    @(negedge clk);
    csb = 1'b0; web = 1'b1; oeb = 1'b0; addr = 16'h4012;
    @(negedge clk);
    csb = 1'b1; ce = 1'b1; a0 = acc_cnt;
    @(negedge clk); ce = 1'b0;
    @(negedge clk); ce = 1'b1;
    @(negedge clk); ce = 1'b0;
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    last_odata = e;
    n_vec++;
    if (odata !== e) begin
      n_err++; $display("FAIL overrun_odata got %h want %h", odata, e);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (acc_cnt - a0 != 1) begin
      n_err++; $display("FAIL overrun_accesses got %0d want 1", acc_cnt - a0);
    end
    n_vec++;
    if (ovr !== 1'b1) begin
      n_err++; $display("FAIL overrun_flag got %b want 1", ovr);
    end
    access(1'b1, 1'b0, 16'h8033, 8'h00, 1'b1);
    n_vec++;
    if (ovr !== 1'b1) begin
      n_err++; $display("FAIL ovr_sticky got %b want 1", ovr);
    end
  endtask

  task automatic test_csb_at_launch();
    logic [7:0] e;
    access(1'b0, 1'b0, 16'hC123, 8'h77, 1'b1);
    @(negedge clk);
    csb = 1'b0; web = 1'b1; oeb = 1'b0; addr = 16'h4012;
    @(negedge clk);
    csb = 1'b1; ce = 1'b1;
    @(negedge clk);
    @(negedge clk);
    csb = 1'b0; web = 1'b1; oeb = 1'b0; addr = 16'hC123;
    @(negedge clk);
    csb = 1'b1; ce = 1'b0;
    n_vec++;
    if (mem_cen !== 4'b1101) begin
      n_err++; $display("FAIL csb_launch_first got %b want 1101", mem_cen);
    end
    repeat (2) @(negedge clk);
    e = mdl[16'h4012];
    n_vec++;
    if (odata !== e) begin
      n_err++; $display("FAIL csb_launch_odata1 got %h want %h", odata, e);
    end
    repeat (2) @(negedge clk);
    ce = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3) begin
        ce = 1'b0;
        n_vec++;
        if (mem_cen !== 4'b0111) begin
          n_err++; $display("FAIL csb_launch_second got %b want 0111", mem_cen);
        end
      end
    end
    last_odata = 8'h77;
    n_vec++;
    if (odata !== 8'h77) begin
      n_err++; $display("FAIL csb_launch_odata2 got %h want 77", odata);
    end
  endtask

  task automatic test_reset_mid();
    int a0;
    @(negedge clk);
    csb = 1'b0; web = 1'b1; oeb = 1'b0; addr = 16'h8033;
    @(negedge clk);
    csb = 1'b1; ce = 1'b1;
    repeat (3) @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (mem_cen !== 4'hF || odata !== 8'h00 || busy !== 1'b0 || ovr !== 1'b0) begin
      n_err++; $display("FAIL reset_mid cen=%b odata=%h busy=%b ovr=%b want 1111/00/0/0", mem_cen, odata, busy, ovr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a0 = acc_cnt;
    repeat (6) @(negedge clk);
    last_odata = 8'h00;
    n_vec++;
    if (odata !== 8'h00 || acc_cnt != a0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_release odata=%h accesses=%0d busy=%b want 00/0/0", odata, acc_cnt - a0, busy);
    end
  endtask

`ifdef MEMCTRL_BISR_EN
  task automatic test_bisr();
    @(negedge clk);
    fail_vld = 1'b1; fail_addr = 16'h0007;
    @(negedge clk);
    fail_vld = 1'b0;
    access(1'b0, 1'b0, 16'h0007, 8'h5A, 1'b0);
    access(1'b1, 1'b0, 16'h0007, 8'h00, 1'b0);
    access(1'b0, 1'b0, 16'h0008, 8'h11, 1'b1);
    access(1'b1, 1'b0, 16'h0008, 8'h00, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_oeb_hold();
    test_no_stage();
    test_random();
    test_overrun();
    test_csb_at_launch();
    test_reset_mid();
`ifdef MEMCTRL_BISR_EN
    test_bisr();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
